// File: rtl/bias_tensor_sink.sv
// Parameter-stream sink: captures one bias tensor beat-by-beat, then holds it
// for random-access reads until the consumer releases it. The consumer-done
// input is named tensor_release because "release" is a reserved word.
module bias_tensor_sink #(
  parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
  parameter int BIAS_TENSOR_SIZE_DIM_1 = 1,
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PRECISION_1       = 3,
  parameter int BIAS_PARALLELISM_DIM_0 = 1,
  parameter int BIAS_PARALLELISM_DIM_1 = 1,
  parameter int IN_DEPTH   = (BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0) *
                             (BIAS_TENSOR_SIZE_DIM_1 / BIAS_PARALLELISM_DIM_1),
  parameter int ADDR_WIDTH = (IN_DEPTH <= 1) ? 1 : $clog2(IN_DEPTH),
  parameter int CNT_WIDTH  = $clog2(IN_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BIAS_PRECISION_0-1:0] data_in [BIAS_PARALLELISM_DIM_0*BIAS_PARALLELISM_DIM_1],
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  input  logic                        flush,
  input  logic                        tensor_release,
  output logic                        tensor_valid,
  output logic [CNT_WIDTH-1:0]        beat_count,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [BIAS_PRECISION_0-1:0] rd_data [BIAS_PARALLELISM_DIM_0*BIAS_PARALLELISM_DIM_1],
  output logic                        rd_data_valid
);

  localparam int LANES = BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1;

  typedef enum logic {FILL, FULL} state_t;

  state_t                      state, state_d;
  logic [ADDR_WIDTH-1:0]       wr_ptr;
  logic [BIAS_PRECISION_0-1:0] mem [IN_DEPTH][LANES];
  logic                        accept;
  logic                        last_beat;

  assign data_in_ready = (state == FILL) && !flush && !rst;
  assign tensor_valid  = (state == FULL);
  assign accept        = data_in_valid && data_in_ready;
  assign last_beat     = (beat_count == CNT_WIDTH'(IN_DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      FILL:    if (accept && last_beat) state_d = FULL;
      FULL:    if (tensor_release) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Release is the only way out of FULL; flush only aborts a partial fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      beat_count <= '0;
    end else if (state == FULL) begin
      if (tensor_release) begin
        wr_ptr     <= '0;
        beat_count <= '0;
      end
    end else if (flush) begin
      wr_ptr     <= '0;
      beat_count <= '0;
    end else if (accept) begin
      wr_ptr     <= last_beat ? '0 : wr_ptr + ADDR_WIDTH'(1);
      beat_count <= beat_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < LANES; j++) mem[wr_ptr][j] <= data_in[j];
    end
  end

  // Non-blocking update gives read-before-write on a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_valid <= 1'b0;
      for (int j = 0; j < LANES; j++) rd_data[j] <= '0;
    end else begin
      rd_data_valid <= rd_en;
      if (rd_en) begin
        for (int j = 0; j < LANES; j++) begin
          if (32'(rd_addr) < IN_DEPTH) rd_data[j] <= mem[rd_addr][j];
          else                         rd_data[j] <= '0;
        end
      end
    end
  end

endmodule
